// File: rtl/genius_playback_sequencer.sv
// genius_playback_sequencer: plays the stored Genius colour sequence on four
// one-hot LEDs, with its own tempo divider off CLOCK_50.
//
// Parameters:
//   CLK_HZ  clock frequency, multiple of 8 and >= 8; phase P = CLK_HZ >> level
//   ADDR_W  sequence memory address width (max 2**ADDR_W steps)
// Ports:
//   CLOCK_50    in   system clock, rising edge
//   reset       in   synchronous active-high, clears all state
//   start       in   1-cycle playback request, honoured only when idle
//   abort       in   stop playback at once, no done pulse
//   level       in   tempo select, latched at accepted start
//   seq_len     in   steps to play, clamped to 2**ADDR_W, latched at start
//   step_addr   out  sequence memory read address
//   step_color  in   colour at step_addr (1-cycle synchronous read)
//   led         out  one-hot LED drive
//   busy        out  high whenever not idle
//   done        out  1-cycle pulse after the last step's dark phase
// Build option:
//   GENIUS_PLAYBACK_GAP_EN  dark phase lasts P cycles instead of 1
module genius_playback_sequencer #(
  parameter int CLK_HZ = 50_000_000,
  parameter int ADDR_W = 5
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        level,
  input  logic [ADDR_W:0]   seq_len,
  output logic [ADDR_W-1:0] step_addr,
  input  logic [1:0]        step_color,
  output logic [3:0]        led,
  output logic              busy,
  output logic              done
);

  // P-1 <= CLK_HZ-1 always fits in clog2(CLK_HZ) bits.
  localparam int CW = $clog2(CLK_HZ);
  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FETCH,
    S_ON,
    S_OFF,
    S_DONE
  } state_t;

  state_t          state;
  logic [1:0]      level_q;
  logic [ADDR_W:0] len_q;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   p_last;
  logic [ADDR_W:0] len_clamp;
  logic            last_step;

  always_comb begin
    p_last    = CW'((CLK_HZ >> level_q) - 1);
    len_clamp = (seq_len > MAX_LEN) ? MAX_LEN : seq_len;
    last_step = ({1'b0, step_addr} == (len_q - 1'b1));
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state     <= S_IDLE;
      level_q   <= '0;
      len_q     <= '0;
      cnt       <= '0;
      step_addr <= '0;
      led       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (abort) begin
      state     <= S_IDLE;
      cnt       <= '0;
      step_addr <= '0;
      led       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            level_q   <= level;
            len_q     <= len_clamp;
            step_addr <= '0;
            cnt       <= '0;
            busy      <= 1'b1;
            if (len_clamp == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_LOAD;
            end
          end
        end
        S_LOAD: state <= S_FETCH;
        S_FETCH: begin
          led   <= 4'b0001 << step_color;
          cnt   <= '0;
          state <= S_ON;
        end
        S_ON: begin
          if (cnt == p_last) begin
            cnt   <= '0;
            led   <= '0;
            state <= S_OFF;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_OFF: begin
`ifdef GENIUS_PLAYBACK_GAP_EN
          if (cnt != p_last) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
`else
          begin
`endif
            if (last_step) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              step_addr <= step_addr + 1'b1;
              state     <= S_LOAD;
            end
          end
        end
        S_DONE: begin
          busy      <= 1'b0;
          step_addr <= '0;
          state     <= S_IDLE;
        end
        default: begin
          busy      <= 1'b0;
          led       <= '0;
          step_addr <= '0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
